// File: rtl/btn_event_ctrl.sv
// btn_event_ctrl: N-button front end for game/menu control.
// Each button goes through a synchroniser, a debounce filter and a rising-edge
// detector; a fixed-priority arbiter (lowest index wins) turns the edges into
// one registered single-cycle press event (one-hot + index).
// Optional feature: define BTN_AUTOREPEAT_EN to enable auto-repeat of the
// most recently pressed button while it stays held and enable stays high.
module btn_event_ctrl #(
    parameter int N_BTN        = 3,
    parameter int SYNC_STAGES  = 2,
    parameter int DB_CYCLES    = 4,
    parameter int REPEAT_DELAY = 10,
    parameter int REPEAT_RATE  = 4,
    localparam int IDX_W       = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] held,
    output logic [N_BTN-1:0] press,
    output logic [IDX_W-1:0] press_idx,
    output logic             event_valid,
    output logic             is_repeat
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    // Value the counter holds one cycle before a level change is accepted.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [N_BTN-1:0] sync_q [SYNC_STAGES];
    logic [N_BTN-1:0] sync_s;
    logic [CNT_W-1:0] cnt_q [N_BTN];
    logic [CNT_W-1:0] cnt_d [N_BTN];
    logic [N_BTN-1:0] held_q, held_d;
    logic [N_BTN-1:0] rise_q, rise_d;
    logic             win_found_s;
    logic [IDX_W-1:0] win_idx_s;
    logic             fresh_s;
    logic             rep_due_s;
    logic [IDX_W-1:0] rep_idx_s;
    logic [N_BTN-1:0] press_q, press_d;
    logic [IDX_W-1:0] press_idx_q, press_idx_d;
    logic             event_valid_q, event_valid_d;
    logic             is_repeat_q, is_repeat_d;

    // Synchroniser chain: raw buttons are asynchronous to clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= btn_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Debounce: a level change is accepted only after DB_CYCLES consecutive disagreeing samples.
    always_comb begin
        held_d = held_q;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_d[i] = '0;
            if (sync_s[i] == held_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                held_d[i] = ~held_q[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        rise_d = held_d & ~held_q;
    end

    // Debounce state, debounced levels and the edge flags captured as held updates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= '0;
            end
            held_q <= '0;
            rise_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            held_q <= held_d;
            rise_q <= rise_d;
        end
    end

    // Fixed-priority pick: the lowest-index edge wins; the others are dropped.
    always_comb begin
        win_idx_s = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            win_idx_s = rise_q[i] ? IDX_W'(i) : win_idx_s;
        end
        win_found_s = |rise_q;
    end

    // Edges seen while disabled are discarded rather than deferred.
    assign fresh_s = enable & win_found_s;

`ifdef BTN_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RC_W    = $clog2(REP_MAX + 1);

    logic [RC_W-1:0]  rep_cnt_q, rep_cnt_d;
    logic [RC_W-1:0]  rep_inc_s, rep_limit_s;
    logic             rep_act_q, rep_act_d;
    logic             rep_first_q, rep_first_d;
    logic [IDX_W-1:0] owner_q, owner_d;

    // Repeat scheduling: a fresh press takes ownership; release or disable ends it.
    always_comb begin
        owner_d     = owner_q;
        rep_act_d   = rep_act_q;
        rep_first_d = rep_first_q;
        rep_cnt_d   = rep_cnt_q;
        rep_due_s   = 1'b0;
        rep_inc_s   = rep_cnt_q + RC_W'(1);
        rep_limit_s = rep_first_q ? RC_W'(REPEAT_DELAY) : RC_W'(REPEAT_RATE);
        if (fresh_s) begin
            owner_d     = win_idx_s;
            rep_act_d   = 1'b1;
            rep_first_d = 1'b1;
            rep_cnt_d   = '0;
        end else if (rep_act_q && enable && held_q[owner_q]) begin
            if (rep_inc_s == rep_limit_s) begin
                rep_due_s   = 1'b1;
                rep_first_d = 1'b0;
                rep_cnt_d   = '0;
            end else begin
                rep_cnt_d = rep_inc_s;
            end
        end else begin
            rep_act_d   = 1'b0;
            rep_first_d = 1'b0;
            rep_cnt_d   = '0;
        end
    end

    // Repeat state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q     <= '0;
            rep_act_q   <= 1'b0;
            rep_first_q <= 1'b0;
            rep_cnt_q   <= '0;
        end else begin
            owner_q     <= owner_d;
            rep_act_q   <= rep_act_d;
            rep_first_q <= rep_first_d;
            rep_cnt_q   <= rep_cnt_d;
        end
    end

    assign rep_idx_s = owner_q;
`else
    logic unused_rep_s;

    assign rep_due_s    = 1'b0;
    assign rep_idx_s    = '0;
    assign unused_rep_s = ^{REPEAT_DELAY[0], REPEAT_RATE[0]};
`endif

    // Event encoding: a fresh press always beats a repeat due in the same cycle.
    always_comb begin
        press_d       = '0;
        press_idx_d   = '0;
        event_valid_d = 1'b0;
        is_repeat_d   = 1'b0;
        if (fresh_s) begin
            press_d[win_idx_s] = 1'b1;
            press_idx_d        = win_idx_s;
            event_valid_d      = 1'b1;
        end else if (rep_due_s) begin
            press_d[rep_idx_s] = 1'b1;
            press_idx_d        = rep_idx_s;
            event_valid_d      = 1'b1;
            is_repeat_d        = 1'b1;
        end else begin
            press_d = '0;
        end
    end

    // Registered event outputs, each pulse lasting exactly one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            press_q       <= '0;
            press_idx_q   <= '0;
            event_valid_q <= 1'b0;
            is_repeat_q   <= 1'b0;
        end else begin
            press_q       <= press_d;
            press_idx_q   <= press_idx_d;
            event_valid_q <= event_valid_d;
            is_repeat_q   <= is_repeat_d;
        end
    end

    assign held        = held_q;
    assign press       = press_q;
    assign press_idx   = press_idx_q;
    assign event_valid = event_valid_q;
    assign is_repeat   = is_repeat_q;

endmodule
